// File: rtl/spram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spram_pkg                                                       |
// | Brief    : Shared types and constants for the byte-enable SPRAM family.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package spram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int WR_NO_RESP     = 0;
  localparam int WR_READ_FIRST  = 1;
  localparam int WR_WRITE_FIRST = 2;

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spram_be_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spram_be_core                                                   |
// | Brief    : Storage array with byte-lane writes and registered response.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spram_be_core
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int WR_MODE    = WR_NO_RESP
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        we,
  input  logic [num_bytes(DATA_WIDTH,BYTE_WIDTH)-1:0] be,
  input  logic [ADDR_WIDTH-1:0]                       addr,
  input  logic [DATA_WIDTH-1:0]                       wdata,
  input  logic                                        resp_en,
  output logic [DATA_WIDTH-1:0]                       rdata
);

  localparam int c_NB    = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_old = r_mem[addr];

  genvar gi;
  generate
    for (gi = 0; gi < c_NB; gi++) begin : g_lane
      assign w_merged[gi*BYTE_WIDTH +: BYTE_WIDTH] =
        be[gi] ? wdata[gi*BYTE_WIDTH +: BYTE_WIDTH] : w_old[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  // Contents are deliberately not reset; the fill engine clears them.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (resp_en) begin
      r_rdata <= (we && (WR_MODE == WR_WRITE_FIRST)) ? w_merged : w_old;
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/spram_be_init.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spram_be_init                                                   |
// | Brief    : Byte-enable SPRAM with valid/ready port and zero-fill engine.   |
// |            Optional macro SPRAM_OUTREG_EN adds an output register stage.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spram_be_init
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int WR_MODE    = WR_NO_RESP
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        init_start,
  output logic                                        init_busy,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic                                        req_we,
  input  logic [num_bytes(DATA_WIDTH,BYTE_WIDTH)-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]                       req_addr,
  input  logic [DATA_WIDTH-1:0]                       req_wdata,
  output logic                                        rd_valid,
  output logic [DATA_WIDTH-1:0]                       rd_data
);

  localparam int                    c_NB       = num_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  w_accept;
  logic                  w_resp;
  logic                  r_resp_vld;
  logic                  w_core_we;
  logic [c_NB-1:0]       w_core_be;
  logic [ADDR_WIDTH-1:0] w_core_addr;
  logic [DATA_WIDTH-1:0] w_core_wdata;
  logic [DATA_WIDTH-1:0] w_core_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter parks at the last address once the fill completes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == c_ADDR_MAX) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (init_start) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign init_busy = (r_state == ST_INIT);
  assign req_ready = (r_state == ST_RUN);
  assign w_accept  = req_valid & req_ready;
  assign w_resp    = w_accept & (~req_we | (WR_MODE != WR_NO_RESP));

  always_comb begin
    w_core_we    = w_accept & req_we;
    w_core_be    = req_be;
    w_core_addr  = req_addr;
    w_core_wdata = req_wdata;
    if (r_state == ST_INIT) begin
      w_core_we    = 1'b1;
      w_core_be    = '1;
      w_core_addr  = r_cnt;
      w_core_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_vld <= 1'b0;
    end else begin
      r_resp_vld <= w_resp;
    end
  end

  spram_be_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .WR_MODE    (WR_MODE)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .we      (w_core_we),
    .be      (w_core_be),
    .addr    (w_core_addr),
    .wdata   (w_core_wdata),
    .resp_en (w_resp),
    .rdata   (w_core_rdata)
  );

`ifdef SPRAM_OUTREG_EN
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_data;

  // A response already in flight when a fill starts still drains out here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_vld <= r_resp_vld;
      if (r_resp_vld) begin
        r_out_data <= w_core_rdata;
      end
    end
  end

  assign rd_valid = r_out_vld;
  assign rd_data  = r_out_data;
`else
  assign rd_valid = r_resp_vld;
  assign rd_data  = w_core_rdata;
`endif

endmodule
`default_nettype wire
